// File: rtl/airi5c_align_shifter_if.sv
// Handshake and data bundle between the alignment shifter and its driver.
// The master side issues load/kill with operands; the slave side returns results.
interface airi5c_align_shifter_if #(
    parameter int n  = 24,
    parameter int SW = 8
);
    logic          kill;
    logic          load;
    logic [n-1:0]  in;
    logic [SW-1:0] shamt;
    logic [n-1:0]  out;
    logic          round_bit;
    logic          sticky_bit;
    logic          busy;
    logic          ready;

    modport master (
        output kill, load, in, shamt,
        input  out, round_bit, sticky_bit, busy, ready
    );

    modport slave (
        input  kill, load, in, shamt,
        output out, round_bit, sticky_bit, busy, ready
    );
endinterface

// File: rtl/airi5c_align_shifter.sv
// Multi-cycle right-shift alignment unit: shifts up to 4 positions per clock,
// accumulating round and sticky bits for the downstream rounding stage.
module airi5c_align_shifter #(
    parameter int n  = 24,
    parameter int SW = 8
) (
    input  logic                   clk,
    input  logic                   n_reset,
    airi5c_align_shifter_if.slave  bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [SW-1:0] SAT_AMT  = SW'(n + 1);
    localparam logic [SW-1:0] MAX_STEP = SW'(4);

    logic [0:0]    state;
    logic [n-1:0]  mant;
    logic          r;
    logic          s;
    logic [SW-1:0] remain;
    logic          ready_q;

    logic [2:0]    k;
    logic [SW-1:0] remain_next;
    logic [n-1:0]  mant_next;
    logic          r_next;
    logic          lost;

    // Bits below the new round position feed sticky together with the old round bit.
    always_comb begin
        k           = (remain > MAX_STEP) ? 3'd4 : remain[2:0];
        remain_next = remain - SW'(k);
        mant_next   = mant >> k;
        r_next      = 1'b0;
        lost        = 1'b0;
        case (k)
            3'd1: begin
                r_next = mant[0];
            end
            3'd2: begin
                r_next = mant[1];
                lost   = mant[0];
            end
            3'd3: begin
                r_next = mant[2];
                lost   = |mant[1:0];
            end
            3'd4: begin
                r_next = mant[3];
                lost   = |mant[2:0];
            end
            default: begin
                r_next = 1'b0;
                lost   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            mant    <= '0;
            r       <= 1'b0;
            s       <= 1'b0;
            remain  <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (bus.kill) begin
                state  <= IDLE;
                mant   <= '0;
                r      <= 1'b0;
                s      <= 1'b0;
                remain <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.load) begin
                            mant <= bus.in;
                            r    <= 1'b0;
                            s    <= 1'b0;
                            if (bus.shamt == '0) begin
                                ready_q <= 1'b1;
                            end else if (bus.shamt >= SAT_AMT) begin
                                mant    <= '0;
                                s       <= |bus.in;
                                ready_q <= 1'b1;
                            end else begin
                                remain <= bus.shamt;
                                state  <= SHIFT;
                            end
                        end
                    end
                    SHIFT: begin
                        mant   <= mant_next;
                        r      <= r_next;
                        s      <= s | r | lost;
                        remain <= remain_next;
                        if (remain_next == '0) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.out        = mant;
    assign bus.round_bit  = r;
    assign bus.sticky_bit = s;
    assign bus.busy       = (state == SHIFT);
    assign bus.ready      = ready_q;
endmodule
